// File: rtl/ssd_word_pager.sv
// Two-page hex pager for four ssdDecode digits: shows the high then the low half of a captured word,
// with leading-zero blanking and an overflow blink. All timing is counted in stateClk ticks.
module ssd_word_pager #(
    parameter int DWELL = 1526,
    parameter int BLINK = 763
) (
    input  logic        stateClk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        ovf,
    input  logic        auto,
    input  logic        page_sel,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic        en0,
    output logic        en1,
    output logic        en2,
    output logic        en3,
    output logic        page,
    output logic        loaded
);

    localparam int MAXV = (DWELL > BLINK) ? DWELL : BLINK;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2
    } state_t;

    state_t          state_reg;
    logic [31:0]     hold_reg;
    logic            hovf_reg;
    logic [CW-1:0]   dwell_reg;
    logic [CW-1:0]   blink_reg;
    logic            phase_reg;
    logic            loaded_reg;

    logic            hi_zero;
    assign hi_zero = (hold_reg[31:16] == 16'h0000);

    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            hold_reg   <= 32'h0;
            hovf_reg   <= 1'b0;
            dwell_reg  <= '0;
            blink_reg  <= '0;
            phase_reg  <= 1'b1;
            loaded_reg <= 1'b0;
        end else begin
            loaded_reg <= load;
            if (load) begin
                // A capture restarts the page sequence and the blink from the on phase.
                hold_reg  <= word;
                hovf_reg  <= ovf;
                dwell_reg <= '0;
                blink_reg <= '0;
                phase_reg <= 1'b1;
                state_reg <= (word[31:16] != 16'h0000) ? SHOW_HI : SHOW_LO;
            end else if (state_reg == SHOW_HI || state_reg == SHOW_LO) begin
                if (hovf_reg) begin
                    if (blink_reg == BLINK_LAST) begin
                        blink_reg <= '0;
                        phase_reg <= ~phase_reg;
                    end else begin
                        blink_reg <= blink_reg + 1'b1;
                    end
                end else begin
                    blink_reg <= '0;
                    phase_reg <= 1'b1;
                end

                if (auto) begin
                    if (dwell_reg == DWELL_LAST) begin
                        dwell_reg <= '0;
                        // An empty high half pins the display to the low page.
                        if (hi_zero || state_reg == SHOW_HI)
                            state_reg <= SHOW_LO;
                        else
                            state_reg <= SHOW_HI;
                    end else begin
                        dwell_reg <= dwell_reg + 1'b1;
                    end
                end else begin
                    dwell_reg <= '0;
                    state_reg <= page_sel ? SHOW_HI : SHOW_LO;
                end
            end else begin
                state_reg <= IDLE;
            end
        end
    end

    logic        show;
    logic        blank;
    logic [15:0] nib;
    logic [3:0]  lead;
    logic [3:0]  en_raw;
    logic [3:0]  en_vec;
    logic [3:0]  dig_vec [4];

    always_comb begin
        nib   = 16'h0000;
        show  = 1'b0;
        blank = 1'b0;
        case (state_reg)
            SHOW_HI: begin
                nib   = hold_reg[31:16];
                show  = 1'b1;
                blank = 1'b1;
            end
            SHOW_LO: begin
                nib   = hold_reg[15:0];
                show  = 1'b1;
                blank = hi_zero;
            end
            default: begin
                nib   = 16'h0000;
                show  = 1'b0;
                blank = 1'b0;
            end
        endcase
    end

    // lead[k] is set when nibble k or any nibble above it is nonzero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign dig_vec[gi] = nib[4*gi +: 4];
            assign lead[gi]    = |nib[15:4*gi];
            if (gi == 0) begin : g_units
                assign en_raw[gi] = 1'b1;
            end else begin : g_upper
                assign en_raw[gi] = lead[gi] | ~blank;
            end
            assign en_vec[gi] = en_raw[gi] & show & phase_reg;
        end
    endgenerate

    assign dig0   = dig_vec[0];
    assign dig1   = dig_vec[1];
    assign dig2   = dig_vec[2];
    assign dig3   = dig_vec[3];
    assign en0    = en_vec[0];
    assign en1    = en_vec[1];
    assign en2    = en_vec[2];
    assign en3    = en_vec[3];
    assign page   = (state_reg == SHOW_HI);
    assign loaded = loaded_reg;

endmodule
